cga_pixel_shifter: RTL

- Producer side of the CGA attribute/pixel interface.
- Accepts VRAM words (text: character + attribute; graphics: two bitmap bytes) through a one-word holding stage and fetches the font row for text cells.
- Serialises each cell into per-dot signals: att_byte, pix_in, c0, c1, pix_640, pix_tandy, plus aligned display-enable and cursor.
- Sits between the CRTC/VRAM sequencer and the attribute/colour stage.

---
 rtl/cga_pkg.sv | 40 ++++
 rtl/cga_fetch_hold.sv | 59 +++++
 rtl/cga_pixel_shifter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/cga_pkg.sv
// rtl/cga_pkg.sv - shared constants, holding states and cell mode encoding for the CGA pixel shifter
package cga_pkg;

  localparam int CELL_DOTS_80   = 8;
  localparam int CELL_DOTS_WIDE = 16;

  typedef enum logic [1:0] {
    HOLD_EMPTY = 2'd0,
    HOLD_FONT  = 2'd1,
    HOLD_FULL  = 2'd2
  } hold_state_t;

  typedef enum logic [2:0] {
    MODE_TEXT80 = 3'd0,
    MODE_TEXT40 = 3'd1,
    MODE_G320   = 3'd2,
    MODE_G640   = 3'd3,
    MODE_TANDY  = 3'd4
  } cell_mode_t;

  // Tandy 16-colour takes priority over 640 when both graphics selects are set.
  function automatic cell_mode_t decode_mode(input logic grph, input logic hres,
                                             input logic m640, input logic tandy);
    cell_mode_t m;
    if (!grph)      m = hres ? MODE_TEXT80 : MODE_TEXT40;
    else if (tandy) m = MODE_TANDY;
    else if (m640)  m = MODE_G640;
    else            m = MODE_G320;
    return m;
  endfunction

  function automatic logic is_text(input cell_mode_t m);
    return (m == MODE_TEXT80) || (m == MODE_TEXT40);
  endfunction

  function automatic logic [3:0] cell_last(input cell_mode_t m);
    return (m == MODE_TEXT80) ? 4'(CELL_DOTS_80 - 1) : 4'(CELL_DOTS_WIDE - 1);
  endfunction

endpackage

// File: rtl/cga_fetch_hold.sv
// rtl/cga_fetch_hold.sv - one-word VRAM holding stage with font row fetch for text cells
module cga_fetch_hold
  import cga_pkg::*;
#(
  parameter int FONT_AW = 11
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               grph_mode,
  input  logic [2:0]         row,
  input  logic               vram_valid,
  input  logic [15:0]        vram_data,
  input  logic               de_in,
  input  logic               cursor_in,
  input  logic [7:0]         font_data,
  input  logic               take,
  output logic               full,
  output logic [15:0]        word,
  output logic               de,
  output logic               cursor,
  output logic [FONT_AW-1:0] font_addr
);

  hold_state_t state;
  logic        accept;

  // A word arriving on the same clk the held word is consumed refills the stage.
  assign accept = vram_valid && ((state == HOLD_EMPTY) || ((state == HOLD_FULL) && take));
  assign full   = (state == HOLD_FULL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= HOLD_EMPTY;
      word      <= 16'h0000;
      de        <= 1'b0;
      cursor    <= 1'b0;
      font_addr <= '0;
    end else begin
      if (accept) begin
        word   <= vram_data;
        de     <= de_in;
        cursor <= cursor_in;
        if (grph_mode) begin
          state <= HOLD_FULL;
        end else begin
          state     <= HOLD_FONT;
          font_addr <= FONT_AW'({vram_data[7:0], row});
        end
      end else if (state == HOLD_FONT) begin
        // Character code is replaced by its font row; attribute stays in the upper byte.
        word[7:0] <= font_data;
        state     <= HOLD_FULL;
      end else if ((state == HOLD_FULL) && take) begin
        state <= HOLD_EMPTY;
      end
    end
  end

endmodule

// File: rtl/cga_pixel_shifter.sv
// rtl/cga_pixel_shifter.sv - serialises held VRAM cells into per-dot CGA pixel and attribute signals
module cga_pixel_shifter
  import cga_pkg::*;
#(
  parameter int FONT_AW = 11
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               dot_ce,
  input  logic               grph_mode,
  input  logic               hres_mode,
  input  logic               mode_640,
  input  logic               tandy_16_mode,
  input  logic [4:0]         row_addr,
  input  logic               vram_valid,
  input  logic [15:0]        vram_data,
  input  logic               de_in,
  input  logic               cursor_in,
  output logic [FONT_AW-1:0] font_addr,
  input  logic [7:0]         font_data,
  output logic               cell_start,
  output logic [7:0]         att_byte,
  output logic               pix_in,
  output logic               c0,
  output logic               c1,
  output logic               pix_640,
  output logic [3:0]         pix_tandy,
  output logic               de_out,
  output logic               cursor_out,
  output logic               underrun,
  input  logic               underrun_clr
);

  logic [3:0]  cnt;
  logic [15:0] sh;
  logic [15:0] sh_next;
  cell_mode_t  mode_q;
  cell_mode_t  mode_next;
  logic        boundary;
  logic        hold_full;
  logic [15:0] hold_word;
  logic        hold_de;
  logic        hold_cursor;
  logic        unused_row;

  assign unused_row = ^row_addr[4:3];

  cga_fetch_hold #(
    .FONT_AW (FONT_AW)
  ) u_fetch_hold (
    .clk        (clk),
    .reset_n    (reset_n),
    .grph_mode  (grph_mode),
    .row        (row_addr[2:0]),
    .vram_valid (vram_valid),
    .vram_data  (vram_data),
    .de_in      (de_in),
    .cursor_in  (cursor_in),
    .font_data  (font_data),
    .take       (boundary),
    .full       (hold_full),
    .word       (hold_word),
    .de         (hold_de),
    .cursor     (hold_cursor),
    .font_addr  (font_addr)
  );

  assign boundary  = dot_ce && (cnt == cell_last(mode_q));
  assign mode_next = boundary ? decode_mode(grph_mode, hres_mode, mode_640, tandy_16_mode) : mode_q;

  // Shift happens when the dot about to be shown starts a new pixel of the active mode.
  always_comb begin
    sh_next = sh;
    if (boundary) begin
      if (!hold_full)               sh_next = 16'h0000;
      else if (is_text(mode_next))  sh_next = {8'h00, hold_word[7:0]};
      else                          sh_next = hold_word;
    end else if (dot_ce) begin
      case (mode_q)
        MODE_TEXT80, MODE_G640: sh_next = sh << 1;
        MODE_TEXT40:            if (cnt[0])         sh_next = sh << 1;
        MODE_G320:              if (cnt[0])         sh_next = sh << 2;
        MODE_TANDY:             if (cnt[1:0] == 2'd3) sh_next = sh << 4;
        default:                sh_next = sh;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= 4'd0;
      mode_q     <= MODE_TEXT80;
      sh         <= 16'h0000;
      cell_start <= 1'b0;
      att_byte   <= 8'h00;
      de_out     <= 1'b0;
      cursor_out <= 1'b0;
      underrun   <= 1'b0;
      pix_in     <= 1'b0;
      c0         <= 1'b0;
      c1         <= 1'b0;
      pix_640    <= 1'b0;
      pix_tandy  <= 4'h0;
    end else begin
      if (dot_ce) cnt <= boundary ? 4'd0 : cnt + 4'd1;
      mode_q     <= mode_next;
      sh         <= sh_next;
      cell_start <= boundary;

      if (boundary) begin
        att_byte   <= (hold_full && is_text(mode_next)) ? hold_word[15:8] : 8'h00;
        de_out     <= hold_full && hold_de;
        cursor_out <= hold_full && hold_cursor;
      end

      // A starved boundary wins over a clear arriving on the same clk.
      if (boundary && !hold_full) underrun <= 1'b1;
      else if (underrun_clr)      underrun <= 1'b0;

      pix_in    <= is_text(mode_next) && sh_next[7];
      c1        <= (mode_next == MODE_G320) && sh_next[15];
      c0        <= (mode_next == MODE_G320) && sh_next[14];
      pix_640   <= (mode_next == MODE_G640) && sh_next[15];
      pix_tandy <= (mode_next == MODE_TANDY) ? sh_next[15:12] : 4'h0;
    end
  end

endmodule
